// File: rtl/rr_arbiter8_pkg.sv
// Shared constants for the round-robin arbiter: FSM state encodings and default sizing.
package rr_arbiter8_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;

    localparam int ARB_N       = 8;
    localparam int ARB_IDXW    = 3;
    localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// rr_pick: combinational round-robin selection, the first request at or after ptr, wrapping.
module rr_pick #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [N-1:0]    pick_oh,
    output logic [IDXW-1:0] pick_idx
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;

    assign any = |req;

    // Rotate so that ptr lands on bit 0; the lowest set bit then wins.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + int'(ptr)) % N];
        end
    end

    assign rot_oh = rot & (~rot + {{(N-1){1'b0}}, 1'b1});

    always_comb begin
        pick_oh = '0;
        for (int i = 0; i < N; i++) begin
            pick_oh[(i + int'(ptr)) % N] = rot_oh[i];
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = pick_idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with a registered one-hot grant held until the owner asserts done.
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate req from ptr
//   ST_GRANT | gnt held until done (or timeout)
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int N       = ARB_N,
    parameter int IDXW    = ARB_IDXW,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout_err
);

    if (N < 2 || (1 << IDXW) != N || TIMEOUT < 2) begin : g_param_check
        $error("rr_arbiter8: invalid N/IDXW/TIMEOUT");
    end

    logic [1:0]      state;
    logic [IDXW-1:0] ptr;
    logic            any;
    logic [N-1:0]    pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            forced;
    logic            release_now;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .any      (any),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    // Down-counter loaded on grant entry; terminal count 0 marks the last allowed cycle.
    logic [TW-1:0] timer;

    assign forced = (state == ST_GRANT) && !done && (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= forced;
            if (state == ST_IDLE && any) begin
                timer <= TW'(TIMEOUT - 1);
            end else if (state == ST_GRANT && timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end
`else
    assign forced      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign release_now = (state == ST_GRANT) && (done || forced);
    assign gnt_valid   = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        gnt     <= pick_oh;
                        gnt_idx <= pick_idx;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt     <= '0;
                        gnt_idx <= '0;
                        ptr     <= gnt_idx + 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic against a
// behavioural owner/pointer model.
module tb_rr_arbiter8;

    localparam int N       = 8;
    localparam int IDXW    = 3;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic            done = 1'b0;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner index (-1 when idle), next search start, grant-cycle count, error pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_err   = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d);
        m_err = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (d) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == TIMEOUT - 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_err   = 1;
        end else begin
            m_cnt++;
        end
`endif
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check_val("gnt", 32'(gnt), 32'(eg));
        check_val("gnt_idx", 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_val("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        compare_model();
    endtask

    // Asserts reset mid-cycle, checks the async clear, releases after the next posedge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        check_val("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_err   = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every requester active; first grant goes to 0.
        req = 8'hFF;
        do_reset();
        step(8'hFF, 1'b0);
        check_val("t1_first_idx", 32'(gnt_idx), 32'd0);

        // Full rotation with one idle cycle per release.
        do_reset();
        for (int k = 0; k <= N; k++) begin
            step(8'hFF, 1'b0);
            check_val("t2_seq_idx", 32'(gnt_idx), 32'(k % N));
            step(8'hFF, 1'b1);
            check_val("t2_idle_valid", 32'(gnt_valid), 32'd0);
        end

        // Pointer at 3 with requesters 2 and 7: grant 7, then wrap to 2.
        do_reset();
        step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        step(8'h84, 1'b0);
        check_val("t3_idx7", 32'(gnt_idx), 32'd7);
        step(8'h84, 1'b1);
        step(8'h84, 1'b0);
        check_val("t3_wrap_idx2", 32'(gnt_idx), 32'd2);

        // Owner 5 drops req; grant held until done; done in idle ignored.
        do_reset();
        step(8'h20, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 1'b0);
            check_val("t4_hold_gnt", 32'(gnt), 32'h20);
        end
        step(8'h00, 1'b1);
        check_val("t4_release", 32'(gnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 1'b1);
            check_val("t4_idle_done", 32'(gnt_valid), 32'd0);
        end

        // Owner never asserts done.
        do_reset();
        step(8'h03, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT; k++) step(8'h03, 1'b0);
        check_val("t5_still_held", 32'(gnt), 32'h01);
        step(8'h03, 1'b0);
        check_val("t5_forced_clear", 32'(gnt), 32'd0);
        check_val("t5_err_pulse", 32'(timeout_err), 32'd1);
        step(8'h03, 1'b0);
        check_val("t5_next_idx", 32'(gnt_idx), 32'd1);
        check_val("t5_err_single", 32'(timeout_err), 32'd0);
`else
        for (int k = 0; k < 3 * TIMEOUT; k++) step(8'h03, 1'b0);
        check_val("t5_held_forever", 32'(gnt), 32'h01);
        check_val("t5_no_err", 32'(timeout_err), 32'd0);
`endif

        // Reset while requester 3 owns the grant.
        do_reset();
        step(8'h08, 1'b0);
        check_val("t6_pre_gnt", 32'(gnt), 32'h08);
        do_reset();
        step(8'h08, 1'b0);
        check_val("t6_after_idx", 32'(gnt_idx), 32'd3);

        // Random traffic, done asserted about a quarter of the time.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] r;
            logic         d;
            r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(0, 255));
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
